// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the three requester toggle-handshake ports, the downstream memory
//   toggle-handshake port and the busy flag used by mem_arbiter.
//
//   Port 0 (loader, write only)   : ld_req/ld_ack, ld_addr, ld_din
//   Port 1 (cartridge ROM, read)  : rom_req/rom_ack, rom_addr, rom_dout
//   Port 2 (backup RAM, rd/wr)    : bk_req/bk_ack, bk_we, bk_addr, bk_din, bk_dout
//   Downstream memory             : dn_req/dn_ack, dn_we, dn_addr, dn_din, dn_dout
//   Status                        : busy
//
//   modport master : arbiter side (drives acks, read data, downstream request)
//   modport slave  : environment side (requesters plus downstream memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16
);
    logic          ld_req;
    logic          ld_ack;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_din;

    logic          rom_req;
    logic          rom_ack;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;

    logic          bk_req;
    logic          bk_ack;
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [DW-1:0] bk_din;
    logic [DW-1:0] bk_dout;

    logic          dn_req;
    logic          dn_ack;
    logic          dn_we;
    logic [AW-1:0] dn_addr;
    logic [DW-1:0] dn_din;
    logic [DW-1:0] dn_dout;

    logic          busy;

    modport master (
        input  ld_req, ld_addr, ld_din,
        input  rom_req, rom_addr,
        input  bk_req, bk_we, bk_addr, bk_din,
        input  dn_ack, dn_dout,
        output ld_ack, rom_ack, rom_dout, bk_ack, bk_dout,
        output dn_req, dn_we, dn_addr, dn_din, busy
    );

    modport slave (
        output ld_req, ld_addr, ld_din,
        output rom_req, rom_addr,
        output bk_req, bk_we, bk_addr, bk_din,
        output dn_ack, dn_dout,
        input  ld_ack, rom_ack, rom_dout, bk_ack, bk_dout,
        input  dn_req, dn_we, dn_addr, dn_din, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Three-port toggle-handshake arbiter in front of one downstream memory.
//   A port is pending while its req differs from its ack. One access is in
//   flight at a time: IDLE grants and toggles dn_req, WAIT holds the
//   downstream request until dn_ack matches, then returns read data and
//   toggles the winner's ack. DRAIN after reset lets an access that was
//   outstanding at reset finish before anything new is issued.
//
//   Priority: port 0 (loader) always wins. Between port 1 (ROM) and port 2
//   (backup RAM) the order is fixed (port 1 first) unless MEM_ARB_RR_EN is
//   defined, which enables round-robin between them.
//
//   Ports:
//     MCLK    : system clock, all state on rising edge
//     RESET_N : asynchronous active-low reset
//     bus     : mem_arbiter_if.master (requester ports, downstream port, busy)
//
//   Parameters: AW word-address width, DW data width.
//   Build option: `define MEM_ARB_RR_EN for round-robin between ports 1 and 2.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 24,
    parameter int DW = 16
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] ST_DRAIN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] PORT_LD  = 2'd0;
    localparam logic [1:0] PORT_ROM = 2'd1;
    localparam logic [1:0] PORT_BK  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    grant;
    logic [1:0]    win;

    logic          ld_ack_q;
    logic          rom_ack_q;
    logic          bk_ack_q;
    logic          dn_req_q;
    logic          dn_we_q;
    logic [AW-1:0] dn_addr_q;
    logic [DW-1:0] dn_din_q;
    logic [DW-1:0] rom_dout_q;
    logic [DW-1:0] bk_dout_q;

    logic          pend_ld;
    logic          pend_rom;
    logic          pend_bk;
    logic          any_pend;
    logic          dn_done;

    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_din;
    logic          win_we;

`ifdef MEM_ARB_RR_EN
    // 0: port 1 is next in line, 1: port 2 is next in line
    logic          rr_ptr;
`endif

    assign pend_ld  = bus.ld_req  ^ ld_ack_q;
    assign pend_rom = bus.rom_req ^ rom_ack_q;
    assign pend_bk  = bus.bk_req  ^ bk_ack_q;
    assign any_pend = pend_ld | pend_rom | pend_bk;
    assign dn_done  = (bus.dn_ack == dn_req_q);

    // Winner selection; only meaningful when any_pend is set.
    always_comb begin
        win = PORT_BK;
        if (pend_ld) begin
            win = PORT_LD;
        end
`ifdef MEM_ARB_RR_EN
        else if (pend_rom && pend_bk) begin
            win = rr_ptr ? PORT_BK : PORT_ROM;
        end
`endif
        else if (pend_rom) begin
            win = PORT_ROM;
        end
    end

    // Request fields of the winning port. ROM is read-only, so it carries no data.
    always_comb begin
        win_addr = bus.ld_addr;
        win_din  = bus.ld_din;
        win_we   = 1'b1;
        case (win)
            PORT_ROM: begin
                win_addr = bus.rom_addr;
                win_din  = '0;
                win_we   = 1'b0;
            end
            PORT_BK: begin
                win_addr = bus.bk_addr;
                win_din  = bus.bk_din;
                win_we   = bus.bk_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_DRAIN;
            grant      <= PORT_LD;
            ld_ack_q   <= 1'b0;
            rom_ack_q  <= 1'b0;
            bk_ack_q   <= 1'b0;
            dn_req_q   <= 1'b0;
            dn_we_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_din_q   <= '0;
            rom_dout_q <= '0;
            bk_dout_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                // Wait out any downstream access that was in flight at reset.
                ST_DRAIN: begin
                    if (dn_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (any_pend) begin
                        grant     <= win;
                        dn_addr_q <= win_addr;
                        dn_din_q  <= win_din;
                        dn_we_q   <= win_we;
                        dn_req_q  <= ~dn_req_q;
                        state     <= ST_WAIT;
`ifdef MEM_ARB_RR_EN
                        if (win != PORT_LD) begin
                            rr_ptr <= (win == PORT_ROM);
                        end
`endif
                    end
                end
                // Downstream fields stay frozen here; requester input changes are ignored.
                ST_WAIT: begin
                    if (dn_done) begin
                        case (grant)
                            PORT_LD: ld_ack_q <= ~ld_ack_q;
                            PORT_ROM: begin
                                rom_ack_q  <= ~rom_ack_q;
                                rom_dout_q <= bus.dn_dout;
                            end
                            PORT_BK: begin
                                bk_ack_q <= ~bk_ack_q;
                                if (!dn_we_q) begin
                                    bk_dout_q <= bus.dn_dout;
                                end
                            end
                            default: ;
                        endcase
                        // No re-arbitration here: the next grant happens from IDLE.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end

    assign bus.ld_ack   = ld_ack_q;
    assign bus.rom_ack  = rom_ack_q;
    assign bus.rom_dout = rom_dout_q;
    assign bus.bk_ack   = bk_ack_q;
    assign bus.bk_dout  = bk_dout_q;
    assign bus.dn_req   = dn_req_q;
    assign bus.dn_we    = dn_we_q;
    assign bus.dn_addr  = dn_addr_q;
    assign bus.dn_din   = dn_din_q;
    // The state register sits in DRAIN during reset; gating with RESET_N keeps
    // busy low while reset is held and raises it for DRAIN once released.
    assign bus.busy     = RESET_N & (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. The bench plays both the
//   requesters and the downstream memory. Inputs change and outputs are
//   sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic MCLK    = 1'b0;
    logic RESET_N = 1'b0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_din;
    logic          cap_we;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    // Wait (bounded) for the arbiter to issue a downstream request and capture it.
    task automatic wait_grant(output bit ok);
        int n = 0;
        while (bus.dn_req === bus.dn_ack && n < 20) begin
            tick(1);
            n++;
        end
        ok       = (bus.dn_req !== bus.dn_ack);
        cap_addr = bus.dn_addr;
        cap_din  = bus.dn_din;
        cap_we   = bus.dn_we;
    endtask

    // Act as the downstream memory: answer the next request after 'delay' cycles.
    task automatic serve(input int delay, input logic [DW-1:0] data, output bit ok);
        wait_grant(ok);
        if (!ok) return;
        tick(delay);
        bus.dn_dout = data;
        bus.dn_ack  = bus.dn_req;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if ({bus.ld_ack, bus.rom_ack, bus.bk_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b want 000", {bus.ld_ack, bus.rom_ack, bus.bk_ack}); end
        checks++; if ({bus.dn_req, bus.dn_we} !== 2'b00) begin errors++; $display("FAIL reset_dn_ctrl got %b want 00", {bus.dn_req, bus.dn_we}); end
        checks++; if ({bus.dn_addr, bus.dn_din, bus.rom_dout, bus.bk_dout} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.dn_addr, bus.dn_din, bus.rom_dout, bus.bk_dout); end
        RESET_N = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %0b want 1", bus.busy); end
        tick(1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
        checks++; if (bus.dn_req !== 1'b0) begin errors++; $display("FAIL idle_dn_req got %0b want 0", bus.dn_req); end
    endtask

    task automatic test_single_read();
        bus.rom_addr = 24'h000100;
        bus.rom_req  = ~bus.rom_req;
        #1;
        checks++; if (bus.dn_req !== 1'b0) begin errors++; $display("FAIL read_early_req got %0b want 0", bus.dn_req); end
        tick(1);
        checks++; if (bus.dn_req !== 1'b1) begin errors++; $display("FAIL read_dn_req got %0b want 1", bus.dn_req); end
        checks++; if (bus.dn_we !== 1'b0) begin errors++; $display("FAIL read_dn_we got %0b want 0", bus.dn_we); end
        checks++; if (bus.dn_addr !== 24'h000100) begin errors++; $display("FAIL read_dn_addr got %h want 000100", bus.dn_addr); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL read_busy got %0b want 1", bus.busy); end
        tick(5);
        bus.dn_dout = 16'hBEEF;
        bus.dn_ack  = 1'b1;
        #1;
        checks++; if (bus.rom_ack !== 1'b0) begin errors++; $display("FAIL read_ack_early got %0b want 0", bus.rom_ack); end
        tick(1);
        checks++; if (bus.rom_ack !== 1'b1) begin errors++; $display("FAIL read_ack got %0b want 1", bus.rom_ack); end
        checks++; if (bus.rom_dout !== 16'hBEEF) begin errors++; $display("FAIL read_dout got %h want beef", bus.rom_dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL read_done_busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_loader_priority();
        bit ok;
        bus.ld_addr  = 24'h000010;
        bus.ld_din   = 16'hA5A5;
        bus.rom_addr = 24'h000200;
        bus.ld_req   = ~bus.ld_req;
        bus.rom_req  = ~bus.rom_req;
        serve(2, 16'h5555, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_grant0 timeout got none want grant"); end
        checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL prio_ld_we got %0b want 1", cap_we); end
        checks++; if (cap_addr !== 24'h000010) begin errors++; $display("FAIL prio_ld_addr got %h want 000010", cap_addr); end
        checks++; if (cap_din !== 16'hA5A5) begin errors++; $display("FAIL prio_ld_din got %h want a5a5", cap_din); end
        checks++; if (bus.ld_ack !== bus.ld_req) begin errors++; $display("FAIL prio_ld_ack got %0b want %0b", bus.ld_ack, bus.ld_req); end
        checks++; if (bus.dn_req !== bus.dn_ack) begin errors++; $display("FAIL prio_no_rearb got dn_req %0b want %0b", bus.dn_req, bus.dn_ack); end
        checks++; if (bus.rom_dout !== 16'hBEEF) begin errors++; $display("FAIL prio_rom_dout_kept got %h want beef", bus.rom_dout); end
        serve(1, 16'h0F0F, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_grant1 timeout got none want grant"); end
        checks++; if (cap_we !== 1'b0 || cap_addr !== 24'h000200) begin errors++; $display("FAIL prio_rom_req got we %0b addr %h want 0 000200", cap_we, cap_addr); end
        checks++; if (bus.rom_dout !== 16'h0F0F) begin errors++; $display("FAIL prio_rom_dout got %h want 0f0f", bus.rom_dout); end
        checks++; if (bus.rom_ack !== bus.rom_req) begin errors++; $display("FAIL prio_rom_ack got %0b want %0b", bus.rom_ack, bus.rom_req); end
    endtask

    task automatic test_grant_order();
        bit ok;
        int port;
        int exp_port [4];
`ifdef MEM_ARB_RR_EN
        exp_port = '{1, 2, 1, 2};
`else
        exp_port = '{1, 1, 1, 1};
`endif
        bus.rom_addr = 24'h000400;
        bus.bk_addr  = 24'h000300;
        bus.bk_we    = 1'b0;
        bus.rom_req  = ~bus.rom_req;
        bus.bk_req   = ~bus.bk_req;
        for (int i = 0; i < 4; i++) begin
            serve(1, 16'h1000 + 16'(i), ok);
            checks++; if (!ok) begin errors++; $display("FAIL order_grant%0d timeout got none want grant", i); end
            port = (cap_addr === 24'h000400) ? 1 : (cap_addr === 24'h000300) ? 2 : 0;
            checks++; if (port != exp_port[i]) begin errors++; $display("FAIL order_%0d got port %0d want %0d", i, port, exp_port[i]); end
            if (port == 1) bus.rom_req = ~bus.rom_req;
            else if (port == 2) bus.bk_req = ~bus.bk_req;
        end
        // One request left on each port; port 1 goes first in both build options.
        serve(0, 16'h2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL order_drain0 timeout got none want grant"); end
        serve(0, 16'h2001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL order_drain1 timeout got none want grant"); end
        checks++; if (bus.rom_dout !== 16'h2000) begin errors++; $display("FAIL order_rom_dout got %h want 2000", bus.rom_dout); end
        checks++; if (bus.bk_dout !== 16'h2001) begin errors++; $display("FAIL order_bk_dout got %h want 2001", bus.bk_dout); end
        checks++; if (bus.rom_ack !== bus.rom_req || bus.bk_ack !== bus.bk_req) begin errors++; $display("FAIL order_acks got %0b%0b want %0b%0b", bus.rom_ack, bus.bk_ack, bus.rom_req, bus.bk_req); end
    endtask

    task automatic test_backup_write();
        bus.bk_we   = 1'b1;
        bus.bk_addr = 24'h3F0000;
        bus.bk_din  = 16'h1234;
        bus.bk_req  = ~bus.bk_req;
        tick(1);
        checks++; if (bus.dn_we !== 1'b1) begin errors++; $display("FAIL bkw_we got %0b want 1", bus.dn_we); end
        checks++; if (bus.dn_addr !== 24'h3F0000) begin errors++; $display("FAIL bkw_addr got %h want 3f0000", bus.dn_addr); end
        checks++; if (bus.dn_din !== 16'h1234) begin errors++; $display("FAIL bkw_din got %h want 1234", bus.dn_din); end
        // Inputs change after grant; the downstream request must not follow.
        bus.bk_addr = 24'h000055;
        bus.bk_din  = 16'hFFFF;
        bus.bk_we   = 1'b0;
        tick(2);
        checks++; if ({bus.dn_we, bus.dn_addr, bus.dn_din} !== {1'b1, 24'h3F0000, 16'h1234}) begin errors++; $display("FAIL bkw_hold got %0b %h %h want 1 3f0000 1234", bus.dn_we, bus.dn_addr, bus.dn_din); end
        bus.dn_dout = 16'hDEAD;
        bus.dn_ack  = bus.dn_req;
        tick(1);
        checks++; if (bus.bk_ack !== bus.bk_req) begin errors++; $display("FAIL bkw_ack got %0b want %0b", bus.bk_ack, bus.bk_req); end
        checks++; if (bus.bk_dout !== 16'h2001) begin errors++; $display("FAIL bkw_dout_kept got %h want 2001", bus.bk_dout); end
    endtask

    task automatic test_reset_mid_op();
        bus.rom_addr = 24'h000500;
        bus.rom_req  = ~bus.rom_req;
        tick(1);
        checks++; if (bus.dn_req !== 1'b1 || bus.dn_ack !== 1'b0) begin errors++; $display("FAIL rst_setup got req %0b ack %0b want 1 0", bus.dn_req, bus.dn_ack); end
        RESET_N     = 1'b0;
        bus.ld_req  = 1'b0;
        bus.rom_req = 1'b0;
        bus.bk_req  = 1'b0;
        #1;
        checks++; if ({bus.ld_ack, bus.rom_ack, bus.bk_ack, bus.dn_req, bus.dn_we, bus.busy} !== 6'b0) begin errors++; $display("FAIL rst_async_ctrl got %b want 000000", {bus.ld_ack, bus.rom_ack, bus.bk_ack, bus.dn_req, bus.dn_we, bus.busy}); end
        checks++; if ({bus.dn_addr, bus.dn_din, bus.rom_dout, bus.bk_dout} !== '0) begin errors++; $display("FAIL rst_async_data got %h/%h/%h/%h want 0", bus.dn_addr, bus.dn_din, bus.rom_dout, bus.bk_dout); end
        bus.dn_ack = 1'b1;
        tick(2);
        RESET_N      = 1'b1;
        bus.rom_addr = 24'h000600;
        bus.rom_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (bus.busy !== 1'b1 || bus.dn_req !== 1'b0) begin errors++; $display("FAIL rst_drain%0d got busy %0b req %0b want 1 0", i, bus.busy, bus.dn_req); end
        end
        bus.dn_ack = 1'b0;
        tick(1);
        checks++; if (bus.dn_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_drain_exit got req %0b busy %0b want 0 0", bus.dn_req, bus.busy); end
        tick(1);
        checks++; if (bus.dn_req !== 1'b1 || bus.dn_addr !== 24'h000600) begin errors++; $display("FAIL rst_first_issue got req %0b addr %h want 1 000600", bus.dn_req, bus.dn_addr); end
        bus.dn_dout = 16'hCAFE;
        bus.dn_ack  = 1'b1;
        tick(1);
        checks++; if (bus.rom_ack !== 1'b1 || bus.rom_dout !== 16'hCAFE) begin errors++; $display("FAIL rst_first_done got ack %0b dout %h want 1 cafe", bus.rom_ack, bus.rom_dout); end
    endtask

    task automatic test_back_to_back();
        bit            ok;
        logic          exp_ack;
        logic [AW-1:0] addrs [100];
        logic [DW-1:0] datas [100];
        for (int i = 0; i < 100; i++) begin
            addrs[i] = AW'($urandom);
            datas[i] = DW'($urandom);
        end
        exp_ack      = bus.rom_ack;
        bus.rom_addr = addrs[0];
        bus.rom_req  = ~bus.rom_req;
        for (int k = 0; k < 100; k++) begin
            wait_grant(ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_grant%0d timeout got none want grant", k); break; end
            checks++; if (cap_addr !== addrs[k] || cap_we !== 1'b0) begin errors++; $display("FAIL b2b_req%0d got addr %h we %0b want %h 0", k, cap_addr, cap_we, addrs[k]); end
            // Queue the next request while this one is still outstanding.
            if (k < 99) begin
                bus.rom_addr = addrs[k+1];
                bus.rom_req  = ~bus.rom_req;
            end
            tick($urandom_range(0, 3));
            bus.dn_dout = datas[k];
            bus.dn_ack  = bus.dn_req;
            tick(1);
            exp_ack = ~exp_ack;
            checks++; if (bus.rom_ack !== exp_ack || bus.rom_dout !== datas[k]) begin errors++; $display("FAIL b2b_done%0d got ack %0b dout %h want %0b %h", k, bus.rom_ack, bus.rom_dout, exp_ack, datas[k]); end
        end
        tick(5);
        checks++; if (bus.dn_req !== bus.dn_ack) begin errors++; $display("FAIL b2b_extra_issue got req %0b want %0b", bus.dn_req, bus.dn_ack); end
        checks++; if (bus.rom_ack !== bus.rom_req || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_final got ack %0b busy %0b want %0b 0", bus.rom_ack, bus.busy, bus.rom_req); end
    endtask

    initial begin
        bus.ld_req   = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_din   = '0;
        bus.rom_req  = 1'b0;
        bus.rom_addr = '0;
        bus.bk_req   = 1'b0;
        bus.bk_we    = 1'b0;
        bus.bk_addr  = '0;
        bus.bk_din   = '0;
        bus.dn_ack   = 1'b0;
        bus.dn_dout  = '0;

        test_reset();
        test_single_read();
        test_loader_priority();
        test_grant_order();
        test_backup_write();
        test_reset_mid_op();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
